// File: rtl/pattern_runner.sv
// pattern_runner: holds a small table of stimulus patterns, applies them one
// by one to a circuit under test and either compares each response against a
// golden value (mode 0) or folds it into a MISR signature (mode 1).
//
// state | meaning
// IDLE  | no run since reset/clear; entries may be loaded
// APPLY | run in progress; one pattern every SETTLE cycles
// DONE  | run finished, results held; load, re-run or clear allowed
module pattern_runner #(
  parameter int NUM_IN = 5,
  parameter int NUM_OUT = 2,
  parameter int DEPTH = 16,
  parameter int SETTLE = 1,
  parameter int SIG_W = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [NUM_IN-1:0]  load_pattern,
  input  logic [NUM_OUT-1:0] load_golden,
  input  logic [NUM_OUT-1:0] load_mask,
  input  logic               start,
  input  logic               mode,
  output logic [NUM_IN-1:0]  cut_in,
  input  logic [NUM_OUT-1:0] cut_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [AW:0]        fail_count,
  output logic [AW-1:0]      first_fail_idx,
  output logic               resp_valid,
  output logic [AW-1:0]      resp_idx,
  output logic [NUM_OUT-1:0] resp_data,
  output logic [SIG_W-1:0]   signature
);

  localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE - 1);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  state_t state, state_nxt;

  logic [NUM_IN-1:0]  pat_mem  [DEPTH];
  logic [NUM_OUT-1:0] gold_mem [DEPTH];
  logic [NUM_OUT-1:0] mask_mem [DEPTH];

  logic [AW:0]        count;
  logic [AW-1:0]      idx;
  logic [AW-1:0]      idx_inc;
  logic [TW-1:0]      timer;
  logic               mode_r;

  logic               start_go;
  logic               clear_go;
  logic               load_go;
  logic               capture;
  logic               last;
  logic               mismatch;
  logic [NUM_OUT-1:0] masked;
  logic [SIG_W-1:0]   sig_nxt;
  logic [AW:0]        fail_nxt;

  assign busy     = (state == APPLY);
  // start and clear win over a simultaneous load offer
  assign start_go = start & ~busy & ~clear;
  assign clear_go = clear & ~busy;
  assign load_ready = ~busy & (count < DEPTH_C) & ~start & ~clear;
  assign load_go  = load_valid & load_ready;

  assign capture  = busy & (timer == '0);
  assign last     = capture & ({1'b0, idx} == count - CNT_ONE);
  assign idx_inc  = idx + AW'(1);

  assign masked   = cut_out & ~mask_mem[idx];
  assign mismatch = |((cut_out ^ gold_mem[idx]) & ~mask_mem[idx]);
  assign sig_nxt  = {signature[SIG_W-2:0], 1'b0}
                  ^ (signature[SIG_W-1] ? SIG_POLY : '0)
                  ^ SIG_W'(masked);
  assign fail_nxt = (mismatch && (fail_count < DEPTH_C)) ? fail_count + CNT_ONE : fail_count;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state decode; clear takes precedence over start when both arrive
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (clear_go)      state_nxt = IDLE;
        else if (start_go) state_nxt = (count != '0) ? APPLY : DONE;
      end
      APPLY: begin
        if (last) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // pattern storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (load_go) begin
      pat_mem[count[AW-1:0]]  <= load_pattern;
      gold_mem[count[AW-1:0]] <= load_golden;
      mask_mem[count[AW-1:0]] <= load_mask;
    end
  end

  // run datapath: entry count, pattern sequencing, capture and result tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count          <= '0;
      idx            <= '0;
      timer          <= '0;
      mode_r         <= 1'b0;
      cut_in         <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      resp_valid     <= 1'b0;
      resp_idx       <= '0;
      resp_data      <= '0;
      signature      <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (clear_go) begin
        count          <= '0;
        done           <= 1'b0;
        pass           <= 1'b0;
        fail_count     <= '0;
        first_fail_idx <= '0;
        resp_idx       <= '0;
        resp_data      <= '0;
        signature      <= '0;
      end else if (start_go) begin
        mode_r         <= mode;
        idx            <= '0;
        timer          <= SETTLE_LD;
        fail_count     <= '0;
        first_fail_idx <= '0;
        signature      <= '0;
        // an empty table finishes immediately with a trivially passing result
        done           <= (count == '0);
        pass           <= (count == '0);
        if (count != '0) cut_in <= pat_mem[0];
      end else begin
        if (load_go) count <= count + CNT_ONE;
        if (busy) begin
          if (capture) begin
            resp_valid <= 1'b1;
            resp_idx   <= idx;
            resp_data  <= cut_out;
            if (mode_r) begin
              signature <= sig_nxt;
            end else begin
              fail_count <= fail_nxt;
              if (mismatch && (fail_count == '0)) first_fail_idx <= idx;
            end
            if (last) begin
              done <= 1'b1;
              pass <= mode_r | (fail_nxt == '0);
            end else begin
              idx    <= idx_inc;
              cut_in <= pat_mem[idx_inc];
              timer  <= SETTLE_LD;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
      end
    end
  end

endmodule
